// File: rtl/minisys_bus_pkg.sv
// Shared bus definitions for the MEM/IO arbiter:
// state encoding, master indices and IO region decode.
package minisys_bus_pkg;

   localparam logic [21:0] IO_PREFIX = 22'h3fffff;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_ACK    = 2'd2;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ACCESS = ST_ACCESS,
      ACK    = ST_ACK
   } state_t;

   // The IO region is the top 1 KiB page of the address map
   function automatic logic is_io(input logic [21:0] page);
      return page == IO_PREFIX;
   endfunction

endpackage

// File: rtl/mem_io_bus_arbiter_if.sv
// Request/ack channels of both masters plus the shared bus
// towards the decoder, with one modport per side.
interface mem_io_bus_arbiter_if;

   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_ack;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_ack;
   logic [31:0] m1_rdata;

   logic        bus_isR;
   logic        bus_isW;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        busy;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_ack, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_ack, m1_rdata,
      output bus_isR, bus_isW, bus_addr, bus_wdata,
      input  bus_rdata,
      output busy
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_ack, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_ack, m1_rdata,
      input  busy
   );

   modport decoder (
      input  bus_isR, bus_isW, bus_addr, bus_wdata,
      output bus_rdata
   );

endinterface

// File: rtl/mem_io_bus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant index
// plus the last-grant register updated on each grant.
module rr_arb2
   import minisys_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       ld,
   output logic       gnt
);

   logic last_q;
   logic last_d;

   // Pick the lone requester, or on a tie the one not served last
   always_comb begin
      gnt = M0;
      unique case (1'b1)
         (req == 2'b11): gnt = ~last_q;
         (req == 2'b10): gnt = M1;
         default:        gnt = M0;
      endcase
   end

   // Remember the winner whenever a grant is taken
   always_comb begin
      last_d = last_q;
      if (ld) begin
         last_d = gnt;
      end
   end

   // Out of reset M1 counts as last served so M0 wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= M1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_io_bus_arbiter.sv
// Shares one MEM/IO bus between the CPU (M0) and DMA (M1) ports
// with round-robin grant and per-region wait states.
module mem_io_bus_arbiter
   import minisys_bus_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1,
   parameter int unsigned IO_WAIT  = 3
) (
   input logic                 clk,
   input logic                 rst,
   mem_io_bus_arbiter_if.slave bus
);

   localparam logic [3:0] MEM_CNT = 4'(MEM_WAIT);
   localparam logic [3:0] IO_CNT  = 4'(IO_WAIT);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        win_q, win_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        isr_q, isr_d;
   logic        isw_q, isw_d;
   logic [1:0]  ack_q, ack_d;
   logic [31:0] rd0_q, rd0_d;
   logic [31:0] rd1_q, rd1_d;

   logic [1:0]  req;
   logic        gnt;
   logic        ld;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;

   assign req = {bus.m1_req, bus.m0_req};

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .ld  (ld),
      .gnt (gnt)
   );

   // Route the granted master's request fields to the holding register
   always_comb begin
      sel_we    = bus.m0_we;
      sel_addr  = bus.m0_addr;
      sel_wdata = bus.m0_wdata;
      if (gnt == M1) begin
         sel_we    = bus.m1_we;
         sel_addr  = bus.m1_addr;
         sel_wdata = bus.m1_wdata;
      end
   end

   // Access sequencer: grant in IDLE, count wait states, pulse ack
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      isr_d   = isr_q;
      isw_d   = isw_q;
      ack_d   = 2'b00;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      ld      = 1'b0;
      unique case (1'b1)
         (state_q == IDLE): begin
            if (|req) begin
               ld      = 1'b1;
               win_d   = gnt;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               cnt_d   = is_io(sel_addr[31:10]) ? IO_CNT : MEM_CNT;
               isr_d   = ~sel_we;
               isw_d   = sel_we;
               state_d = ACCESS;
            end
         end
         (state_q == ACCESS): begin
            if (cnt_q == 4'd0) begin
               isr_d   = 1'b0;
               isw_d   = 1'b0;
               ack_d   = (win_q == M1) ? 2'b10 : 2'b01;
               state_d = ACK;
               if (!we_q) begin
                  if (win_q == M1) begin
                     rd1_d = bus.bus_rdata;
                  end else begin
                     rd0_d = bus.bus_rdata;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         (state_q == ACK): begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Register state and every bus-facing output
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         win_q   <= M0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         isr_q   <= 1'b0;
         isw_q   <= 1'b0;
         ack_q   <= 2'b00;
         rd0_q   <= 32'h0;
         rd1_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         isr_q   <= isr_d;
         isw_q   <= isw_d;
         ack_q   <= ack_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

   assign bus.bus_isR   = isr_q;
   assign bus.bus_isW   = isw_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.m0_ack    = ack_q[0];
   assign bus.m1_ack    = ack_q[1];
   assign bus.m0_rdata  = rd0_q;
   assign bus.m1_rdata  = rd1_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_io_bus_arbiter.sv
// Randomised bench for mem_io_bus_arbiter against a
// transaction-level model of grant order, latency and read data.
module tb_mem_io_bus_arbiter;
   import minisys_bus_pkg::*;

   localparam int MW = 1;
   localparam int IW = 3;
   localparam logic [31:0] K = 32'h5A5A_1234;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_io_bus_arbiter_if ifc ();
   mem_io_bus_arbiter_if ifz ();

   mem_io_bus_arbiter #(.MEM_WAIT(MW), .IO_WAIT(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   mem_io_bus_arbiter #(.MEM_WAIT(0), .IO_WAIT(3)) dut_z (
      .clk (clk),
      .rst (rst),
      .bus (ifz)
   );

   logic        fix_en;
   logic [31:0] fix_val;

   // Decoder stand-in: fixed value or an address-derived pattern
   always_comb ifc.bus_rdata = fix_en ? fix_val : (ifc.bus_addr ^ K);
   assign ifz.bus_rdata = 32'h0;

   int checks = 0;
   int errors = 0;
   logic        lg;
   logic [31:0] rd_m [2];

   function automatic int wt(input logic [31:0] a);
      return (a[31:10] == 22'h3fffff) ? IW : MW;
   endfunction

   function automatic logic ack_of(input logic m);
      return m ? ifc.m1_ack : ifc.m0_ack;
   endfunction

   function automatic logic [31:0] rdata_of(input logic m);
      return m ? ifc.m1_rdata : ifc.m0_rdata;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(1, 0) == 1) begin
         a = {22'h3fffff, 10'($urandom)};
      end else begin
         a = $urandom & 32'h7FFF_FFFC;
      end
      return a;
   endfunction

   task automatic set_m(input logic m, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      if (m) begin
         ifc.m1_req = r; ifc.m1_we = w;
         ifc.m1_addr = a; ifc.m1_wdata = d;
      end else begin
         ifc.m0_req = r; ifc.m0_we = w;
         ifc.m0_addr = a; ifc.m0_wdata = d;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_single(input logic m, input logic we,
                            input logic [31:0] a, input logic [31:0] d);
      int w, ack_s, stb, bad;
      logic [31:0] exp_rd;
      w = wt(a); ack_s = 0; stb = 0; bad = 0;
      exp_rd = rd_m[m];
      if (!we) exp_rd = fix_en ? fix_val : (a ^ K);
      set_m(m, 1'b1, we, a, d);
      for (int s = 1; s <= 40 && ack_s == 0; s++) begin
         step();
         if (s == 1) set_m(m, 1'b1, we, ~a, ~d);
         if (ifc.bus_isR || ifc.bus_isW) begin
            stb++;
            if (ifc.bus_isR !== !we || ifc.bus_isW !== we ||
                ifc.bus_addr !== a || (we && ifc.bus_wdata !== d)) bad++;
         end
         if (ack_of(!m)) bad++;
         if (ack_of(m)) ack_s = s;
      end
      set_m(m, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (ack_s != w + 2) begin
         errors++;
         $display("FAIL single_latency m%0d got %0d exp %0d", m, ack_s, w + 2);
      end
      checks++;
      if (stb != w + 1) begin
         errors++;
         $display("FAIL single_strobes m%0d got %0d exp %0d", m, stb, w + 1);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL single_bus m%0d got %0d bad cycles exp 0", m, bad);
      end
      checks++;
      if (rdata_of(m) !== exp_rd) begin
         errors++;
         $display("FAIL single_rdata m%0d got %h exp %h", m, rdata_of(m), exp_rd);
      end
      lg = m;
      rd_m[m] = exp_rd;
      step();
      checks++;
      if (ack_of(m) !== 1'b0 || ifc.busy !== 1'b0) begin
         errors++;
         $display("FAIL single_end m%0d got ack %b busy %b exp 0 0",
                  m, ack_of(m), ifc.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++;
      if ({ifc.m0_ack, ifc.m1_ack, ifc.bus_isR, ifc.bus_isW, ifc.busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 00000",
                  {ifc.m0_ack, ifc.m1_ack, ifc.bus_isR, ifc.bus_isW, ifc.busy});
      end
      checks++;
      if ({ifc.bus_addr, ifc.bus_wdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_bus got %h %h exp 0", ifc.bus_addr, ifc.bus_wdata);
      end
      checks++;
      if ({ifc.m0_rdata, ifc.m1_rdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h %h exp 0", ifc.m0_rdata, ifc.m1_rdata);
      end
      rst = 1'b0;
      step();
      lg = M1;
      rd_m[0] = 32'h0;
      rd_m[1] = 32'h0;
   endtask

   task automatic test_both(input logic w0, input logic w1);
      logic [31:0] aa [2];
      logic        ww [2];
      logic        ex;
      int n, nxt;
      aa[0] = rand_addr(); aa[1] = rand_addr();
      ww[0] = w0; ww[1] = w1;
      set_m(M0, 1'b1, w0, aa[0], 32'h0BAD_0000);
      set_m(M1, 1'b1, w1, aa[1], 32'h0BAD_0001);
      ex = ~lg;
      nxt = wt(aa[ex]) + 2;
      n = 0;
      for (int s = 1; s <= 200 && n < 4; s++) begin
         step();
         if (ifc.m0_ack || ifc.m1_ack) begin
            checks++;
            if ({ifc.m1_ack, ifc.m0_ack} !== (ex ? 2'b10 : 2'b01)) begin
               errors++;
               $display("FAIL both_order got %b exp m%0d",
                        {ifc.m1_ack, ifc.m0_ack}, ex);
            end
            checks++;
            if (s != nxt) begin
               errors++;
               $display("FAIL both_time got %0d exp %0d", s, nxt);
            end
            if (!ww[ex]) rd_m[ex] = aa[ex] ^ K;
            checks++;
            if (rdata_of(ex) !== rd_m[ex]) begin
               errors++;
               $display("FAIL both_rdata got %h exp %h", rdata_of(ex), rd_m[ex]);
            end
            lg = ex;
            ex = ~ex;
            nxt = s + 1 + wt(aa[ex]) + 2;
            n++;
         end
      end
      set_m(M0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(M1, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL both_count got %0d exp 4", n);
      end
      step();
      checks++;
      if (ifc.busy !== 1'b0) begin
         errors++;
         $display("FAIL both_idle got %b exp 0", ifc.busy);
      end
   endtask

   task automatic test_drop();
      logic [31:0] ar, a1;
      int n0, t0, t1;
      ar = $urandom & 32'h0FFF_FFFC;
      a1 = rand_addr();
      n0 = 0; t0 = 0; t1 = 0;
      set_m(M0, 1'b1, 1'b0, ar, 32'h0);
      for (int s = 1; s <= 60 && t1 == 0; s++) begin
         step();
         if (s == 1) begin
            set_m(M0, 1'b0, 1'b0, 32'h0, 32'h0);
            set_m(M1, 1'b1, 1'b1, a1, 32'hCAFE_0001);
         end
         if (ifc.m0_ack) begin
            n0++;
            if (t0 == 0) t0 = s;
         end
         if (ifc.m1_ack) begin
            t1 = s;
            set_m(M1, 1'b0, 1'b0, 32'h0, 32'h0);
         end
      end
      checks++;
      if (n0 != 1 || t0 != wt(ar) + 2) begin
         errors++;
         $display("FAIL drop_m0_ack got %0d acks at %0d exp 1 at %0d",
                  n0, t0, wt(ar) + 2);
      end
      checks++;
      if (t1 != wt(ar) + 2 + 1 + wt(a1) + 2) begin
         errors++;
         $display("FAIL drop_m1_time got %0d exp %0d",
                  t1, wt(ar) + 2 + 1 + wt(a1) + 2);
      end
      rd_m[0] = ar ^ K;
      checks++;
      if (ifc.m0_rdata !== rd_m[0]) begin
         errors++;
         $display("FAIL drop_rdata got %h exp %h", ifc.m0_rdata, rd_m[0]);
      end
      lg = M1;
      step();
   endtask

   task automatic test_reset_mid();
      int n;
      set_m(M1, 1'b1, 1'b1, 32'hFFFF_FC60, 32'h7777_0000);
      step();
      step();
      checks++;
      if (ifc.busy !== 1'b1 || ifc.bus_isW !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_active got busy %b isW %b exp 1 1",
                  ifc.busy, ifc.bus_isW);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({ifc.bus_isR, ifc.bus_isW, ifc.busy, ifc.m0_ack, ifc.m1_ack} !== 5'b0) begin
         errors++;
         $display("FAIL rstmid_drop got %b exp 00000",
                  {ifc.bus_isR, ifc.bus_isW, ifc.busy, ifc.m0_ack, ifc.m1_ack});
      end
      rst = 1'b0;
      set_m(M1, 1'b0, 1'b0, 32'h0, 32'h0);
      n = 0;
      repeat (8) begin
         step();
         if (ifc.m0_ack || ifc.m1_ack || ifc.busy) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL rstmid_quiet got %0d active cycles exp 0", n);
      end
      lg = M1;
      rd_m[0] = 32'h0;
      rd_m[1] = 32'h0;
      checks++;
      if (ifc.m0_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_rdata got %h exp 0", ifc.m0_rdata);
      end
   endtask

   task automatic test_zero_wait();
      int stb, ack_s, bad;
      stb = 0; ack_s = 0; bad = 0;
      ifz.m0_req = 1'b1; ifz.m0_we = 1'b1;
      ifz.m0_addr = 32'h0000_0100; ifz.m0_wdata = 32'hABCD_0123;
      for (int s = 1; s <= 10 && ack_s == 0; s++) begin
         step();
         if (ifz.bus_isW) begin
            stb++;
            if (ifz.bus_addr !== 32'h0000_0100 || ifz.bus_wdata !== 32'hABCD_0123) bad++;
         end
         if (ifz.bus_isR) bad++;
         if (ifz.m0_ack) ack_s = s;
      end
      ifz.m0_req = 1'b0;
      checks++;
      if (stb != 1 || bad != 0) begin
         errors++;
         $display("FAIL zero_strobe got %0d cycles %0d bad exp 1 0", stb, bad);
      end
      checks++;
      if (ack_s != 2) begin
         errors++;
         $display("FAIL zero_latency got %0d exp 2", ack_s);
      end
      step();
      checks++;
      if (ifz.m0_ack !== 1'b0 || ifz.busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_end got ack %b busy %b exp 0 0", ifz.m0_ack, ifz.busy);
      end
   endtask

   initial begin
      fix_en = 1'b0;
      fix_val = 32'h0;
      set_m(M0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(M1, 1'b0, 1'b0, 32'h0, 32'h0);
      ifz.m0_req = 1'b0; ifz.m0_we = 1'b0;
      ifz.m0_addr = 32'h0; ifz.m0_wdata = 32'h0;
      ifz.m1_req = 1'b0; ifz.m1_we = 1'b0;
      ifz.m1_addr = 32'h0; ifz.m1_wdata = 32'h0;
      lg = M1;
      rd_m[0] = 32'h0;
      rd_m[1] = 32'h0;

      test_reset();
      test_both(1'b0, 1'b0);
      fix_en = 1'b1;
      fix_val = 32'hDEAD_BEEF;
      do_single(M0, 1'b0, 32'h0000_0040, 32'h0);
      fix_en = 1'b0;
      do_single(M1, 1'b1, 32'hFFFF_FC60, 32'h1234_5678);
      test_both(1'b1, 1'b0);
      test_drop();
      repeat (24) begin
         do_single(1'($urandom), 1'($urandom), rand_addr(), $urandom);
      end
      test_reset_mid();
      do_single(M0, 1'b0, 32'h0000_0080, 32'h0);
      test_both(1'b0, 1'b1);
      test_zero_wait();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
